imm_decode_pipe: RTL and testbench
==================================

Name: imm_decode_pipe

Overview:
- Registered, parametrised immediate-generation stage between fetch and register-read.
- Classifies each incoming instruction itself from its opcode, then produces the XLEN-wide immediate and a type code.
- Covers all RV base formats: R, I, S, B, U and J, plus the shift-amount special case.
- Sits behind a valid/ready handshake with a 2-entry skid buffer, so back-pressure from decode never drops or duplicates instructions.
- Synchronous flush for branch redirects.

Parameters:
- XLEN, 32, immediate width; legal values 32 or 64; sign extension fills to XLEN.
- TAG_W, 32, width of the sideband tag (PC) carried with each instruction.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  raw instruction.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts the entry.
- out_imm  out  XLEN  decoded immediate.
- out_type  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=unknown.
- out_instr  out  32  instruction, passed through.
- out_tag  out  TAG_W  tag, passed through.

Behaviour:
- Reset (rst_n=0 at an edge):
  - out_valid=0, skid empty, in_ready=1.
  - out_imm, out_type, out_instr and out_tag are all zero.
- Type decode from instr[6:0]:
  - I: 0010011, 0000011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011.
  - Anything else: unknown (7).
- Immediate construction (s = instr[31], sign-extended to XLEN):
  - I: instr[31:20].
  - S: instr[31:25], instr[11:7].
  - B: instr[31], instr[7], instr[30:25], instr[11:8], 0.
  - U: instr[31:12], then 12 zeros; sign-extended above bit 31 when XLEN=64.
  - J: instr[31], instr[19:12], instr[20], instr[30:21], 0.
  - R and unknown: 0.
- Shift exception:
  - Applies to opcode 0010011 with funct3 001 or 101.
  - Immediate is the zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - Funct7 bits are excluded.
- Handshake and latency:
  - An input is accepted on any edge where in_valid && in_ready.
  - Latency is 1 cycle: an accepted input appears on the out_* registers at the next edge when the output slot is empty or is being drained.
  - An output entry retires on an edge where out_valid && out_ready.
  - All out_* signals are held stable while out_valid && !out_ready.
- Skid buffer:
  - If the input is accepted while the output slot is occupied and not draining, it goes to the skid entry.
  - in_ready = !skid_full, registered.
  - When the output retires, the skid entry moves to the output on the same edge.
  - Strict FIFO order is kept.
- Simultaneous events:
  - Accept plus retire with the skid empty: the output is replaced directly; occupancy is unchanged.
  - Accept plus retire with the skid full: cannot occur, because in_ready=0.
- Flush:
  - Next state is out_valid=0, skid empty, in_ready=1.
  - Any input presented in the flush cycle is dropped.
  - flush has priority over the handshake; reset has priority over flush.
- Reset mid-operation behaves exactly like reset from idle.

Optional Feature:
- Macro: IMM_DECODE_ILLEGAL_EN.
- Defined:
  - Adds output port out_illegal (1 bit, registered with the entry, reset 0).
  - out_illegal is 1 when the type is unknown, or when in_instr[1:0] != 2'b11.
  - Such entries still flow through with imm=0 and type=7.
- Not defined: no port, no logic; unknown entries carry type=7 only.

Test Plan:
- XLEN=32, out_ready=1; send 0xFFF00093 (addi x1,x0,-1) -> one cycle later out_valid=1, out_type=1, out_imm=0xFFFFFFFF.
- Send 0xFE112E23 (sw x1,-4(x2)) -> type 2, imm 0xFFFFFFFC. Then 0xFFDFF06F (jal x0,-4) -> type 5, imm 0xFFFFFFFC. Then 0x123452B7 (lui) -> type 4, imm 0x12345000.
- Send 0x4030D093 (srai x1,x1,3) -> type 1, imm 0x00000003, not 0x403.
- Hold out_ready=0 and stream tags 1, 2, 3 -> tags 1 and 2 accepted, in_ready=0 after the second acceptance, tag 3 held upstream. Release out_ready -> outputs 1, 2, 3 in order, no gaps in acceptance, no duplicates.
- With both entries full, assert flush for one cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, the presented input never appears.
- XLEN=64, send 0x800002B7 -> imm 0xFFFFFFFF80000000. With IMM_DECODE_ILLEGAL_EN, send 0x00000000 -> out_illegal=1, type 7, imm 0.

Source files
------------

// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: registered immediate-generation stage between fetch and
// register-read. Classifies each instruction from its opcode, builds the
// XLEN-wide immediate, and sits behind a valid/ready handshake with a
// 2-entry skid buffer (output slot + skid entry). Synchronous flush.
// Optional feature macro: IMM_DECODE_ILLEGAL_EN adds a registered
// out_illegal flag for unknown opcodes or non-32-bit encodings.
module imm_decode_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_DECODE_ILLEGAL_EN
  ,
  output logic             out_illegal
`endif
);

  localparam logic [2:0] T_R = 3'd0;
  localparam logic [2:0] T_I = 3'd1;
  localparam logic [2:0] T_S = 3'd2;
  localparam logic [2:0] T_B = 3'd3;
  localparam logic [2:0] T_U = 3'd4;
  localparam logic [2:0] T_J = 3'd5;
  localparam logic [2:0] T_X = 3'd7;

  function automatic logic [2:0] decode_type(input logic [31:0] instr);
    logic [2:0] t;
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: t = T_I;
      7'b0100011: t = T_S;
      7'b1100011: t = T_B;
      7'b0110111, 7'b0010111: t = T_U;
      7'b1101111: t = T_J;
      7'b0110011: t = T_R;
      default:    t = T_X;
    endcase
    return t;
  endfunction

  // Builds a 32-bit sign-extended immediate, then widens it to XLEN with
  // sign extension (U-type therefore sign-extends above bit 31 on RV64).
  function automatic logic signed [XLEN-1:0] decode_imm(input logic [31:0] instr,
                                                        input logic [2:0]  t);
    logic signed [31:0] v32;
    logic [5:0]         shamt;
    shamt = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
    v32   = '0;
    case (t)
      T_I: begin
        // Shift-immediates carry funct7 in the upper bits; only shamt counts.
        if (instr[6:0] == 7'b0010011 && instr[13:12] == 2'b01)
          v32 = {26'b0, shamt};
        else
          v32 = {{20{instr[31]}}, instr[31:20]};
      end
      T_S: v32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      T_B: v32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      T_U: v32 = {instr[31:12], 12'b0};
      T_J: v32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: v32 = '0;
    endcase
    return XLEN'(v32);
  endfunction

  logic                    skid_full;
  logic                    accept;
  logic                    slot_free;
  logic [2:0]              type_p0;
  logic signed [XLEN-1:0]  imm_p0;
  logic [2:0]              skid_type;
  logic signed [XLEN-1:0]  skid_imm;
  logic [31:0]             skid_instr;
  logic [TAG_W-1:0]        skid_tag;
`ifdef IMM_DECODE_ILLEGAL_EN
  logic                    ill_p0;
  logic                    skid_ill;
`endif

  assign in_ready  = !skid_full;
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;

  // Stage p0: combinational decode of the incoming instruction
  always_comb begin
    type_p0 = decode_type(in_instr);
    imm_p0  = decode_imm(in_instr, type_p0);
`ifdef IMM_DECODE_ILLEGAL_EN
    ill_p0  = (type_p0 == T_X) || (in_instr[1:0] != 2'b11);
`endif
  end

  // Output slot: refilled from the skid entry first, else straight from p0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_type    <= '0;
      out_instr   <= '0;
      out_tag     <= '0;
`ifdef IMM_DECODE_ILLEGAL_EN
      out_illegal <= 1'b0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (slot_free) begin
      if (skid_full) begin
        out_valid   <= 1'b1;
        out_imm     <= skid_imm;
        out_type    <= skid_type;
        out_instr   <= skid_instr;
        out_tag     <= skid_tag;
`ifdef IMM_DECODE_ILLEGAL_EN
        out_illegal <= skid_ill;
`endif
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_imm     <= imm_p0;
        out_type    <= type_p0;
        out_instr   <= in_instr;
        out_tag     <= in_tag;
`ifdef IMM_DECODE_ILLEGAL_EN
        out_illegal <= ill_p0;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Skid occupancy: fills when the slot is stalled, empties when it drains
  always_ff @(posedge clk) begin
    if (!rst_n || flush)
      skid_full <= 1'b0;
    else if (slot_free)
      skid_full <= 1'b0;
    else if (accept)
      skid_full <= 1'b1;
  end

  // Skid payload: captured only when an accepted entry cannot reach the slot
  always_ff @(posedge clk) begin
    if (accept && !slot_free) begin
      skid_imm   <= imm_p0;
      skid_type  <= type_p0;
      skid_instr <= in_instr;
      skid_tag   <= in_tag;
`ifdef IMM_DECODE_ILLEGAL_EN
      skid_ill   <= ill_p0;
`endif
    end
  end

endmodule

// File: tb/tb_imm_decode_pipe.sv
module tb_imm_decode_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_tag = '0;

  logic        r32, v32, r64, v64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  type32, type64;
  logic [31:0] instr32, instr64, tag32, tag64;
`ifdef IMM_DECODE_ILLEGAL_EN
  logic        ill32, ill64;
`endif

  imm_decode_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(v32), .out_ready(out_ready), .out_imm(imm32), .out_type(type32),
    .out_instr(instr32), .out_tag(tag32)
`ifdef IMM_DECODE_ILLEGAL_EN
    , .out_illegal(ill32)
`endif
  );

  imm_decode_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_type(type64),
    .out_instr(instr64), .out_tag(tag64)
`ifdef IMM_DECODE_ILLEGAL_EN
    , .out_illegal(ill64)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] tag;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  int   tagc = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_type(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return 3'd1;
      7'h23: return 3'd2;
      7'h63: return 3'd3;
      7'h37, 7'h17: return 3'd4;
      7'h6F: return 3'd5;
      7'h33: return 3'd0;
      default: return 3'd7;
    endcase
  endfunction

  // Immediate value computed as an integer from the field weights.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input int xl);
    longint v;
    v = 0;
    case (ref_type(i))
      3'd1: begin
        if (i[6:0] == 7'h13 && (i[14:12] == 3'd1 || i[14:12] == 3'd5))
          v = (xl == 32) ? longint'(i[24:20]) : longint'(i[25:20]);
        else begin
          v = longint'(i[31:20]);
          if (v >= 2048) v -= 4096;
        end
      end
      3'd2: begin
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (v >= 2048) v -= 4096;
      end
      3'd3: begin
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
            longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      3'd4: begin
        v = longint'(i[31:12]) * 4096;
        if (v >= 64'sh80000000) v -= 64'sh100000000;
      end
      3'd5: begin
        v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
            longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    return (xl == 32) ? {32'h0, v[31:0]} : 64'(v);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [31:0] r2;
    int          k;
    logic [6:0]  op;
    r  = $urandom();
    r2 = $urandom();
    k  = $urandom_range(0, 11);
    case (k)
      0: op = 7'h13;  1: op = 7'h03;  2: op = 7'h67;  3: op = 7'h73;
      4: op = 7'h23;  5: op = 7'h63;  6: op = 7'h37;  7: op = 7'h17;
      8: op = 7'h6F;  9: op = 7'h33;
      default: op = r2[6:0];
    endcase
    if (k == 0 && r2[8]) r[13:12] = 2'b01;
    return {r[31:7], op};
  endfunction

  // Reference occupancy model: a FIFO of at most two accepted entries
  always @(posedge clk) begin
    bit   ret, acc;
    ent_t e;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      ret = (q.size() > 0) && out_ready;
      acc = in_valid && (q.size() < 2);
      if (ret) void'(q.pop_front());
      if (acc) begin
        e.instr = in_instr;
        e.tag   = in_tag;
        q.push_back(e);
      end
    end
  end

  // Every-cycle comparison of both DUT widths against the model
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("valid32", v32, q.size() > 0);
      check("ready32", r32, q.size() < 2);
      check("valid64", v64, q.size() > 0);
      check("ready64", r64, q.size() < 2);
      if (q.size() > 0) begin
        check("type32", type32, ref_type(q[0].instr));
        check("type64", type64, ref_type(q[0].instr));
        check("imm32", imm32, ref_imm(q[0].instr, 32));
        check("imm64", imm64, ref_imm(q[0].instr, 64));
        check("instr32", instr32, q[0].instr);
        check("instr64", instr64, q[0].instr);
        check("tag32", tag32, q[0].tag);
        check("tag64", tag64, q[0].tag);
`ifdef IMM_DECODE_ILLEGAL_EN
        check("ill32", ill32, ref_type(q[0].instr) == 3'd7 || q[0].instr[1:0] != 2'b11);
        check("ill64", ill64, ref_type(q[0].instr) == 3'd7 || q[0].instr[1:0] != 2'b11);
`endif
      end
    end
  end

  task automatic send_chk(input string name, input logic [31:0] instr, input logic [2:0] t,
                          input logic [31:0] e32, input logic [63:0] e64);
    @(negedge clk);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_tag    = tagc++;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({name, "_valid"}, v32, 1'b1);
    check({name, "_type"}, type32, t);
    check({name, "_imm32"}, imm32, e32);
    check({name, "_imm64"}, imm64, e64);
  endtask

  logic [31:0] got[$];
  bit          acc_now;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", v32, 1'b0);
    check("rst_ready", r32, 1'b1);
    check("rst_imm", imm32, 0);
    check("rst_type", type32, 0);
    check("rst_instr", instr32, 0);
    check("rst_tag", tag32, 0);
    check("rst_imm64", imm64, 0);
    check("model_addi", ref_imm(32'hFFF00093, 32), 64'hFFFFFFFF);
    check("model_srai", ref_imm(32'h4030D093, 64), 64'h3);
    check("model_lui64", ref_imm(32'h800002B7, 64), 64'hFFFFFFFF80000000);
    check("model_beq", ref_imm(32'hFE000EE3, 32), 64'hFFFFFFFC);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    send_chk("addi", 32'hFFF00093, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    send_chk("sw",   32'hFE112E23, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    send_chk("jal",  32'hFFDFF06F, 3'd5, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    send_chk("lui",  32'h123452B7, 3'd4, 32'h12345000, 64'h0000000012345000);
    send_chk("srai", 32'h4030D093, 3'd1, 32'h00000003, 64'h3);
    send_chk("beq",  32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    send_chk("add",  32'h002081B3, 3'd0, 32'h0, 64'h0);
    send_chk("lui64", 32'h800002B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000);
    send_chk("zero", 32'h00000000, 3'd7, 32'h0, 64'h0);
`ifdef IMM_DECODE_ILLEGAL_EN
    check("zero_illegal", ill32, 1'b1);
`endif

    // Back-pressure: tags 1,2 accepted, 3 held upstream
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_tag    = 1;
    @(negedge clk);
    check("bp_ready_after1", r32, 1'b1);
    in_tag = 2;
    @(negedge clk);
    check("bp_ready_after2", r32, 1'b0);
    check("bp_head1", tag32, 1);
    in_tag = 3;
    @(negedge clk);
    check("bp_hold_ready", r32, 1'b0);
    check("bp_hold_head", tag32, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (v32) got.push_back(tag32);
      acc_now = in_valid && r32;
      @(negedge clk);
      if (acc_now) in_valid = 1'b0;
    end
    check("bp_count", got.size(), 3);
    for (int k = 0; k < got.size() && k < 3; k++)
      check("bp_order", got[k], k + 1);

    // Flush with both entries full and an input presented
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 10;
    @(negedge clk);
    in_tag = 11;
    @(negedge clk);
    check("fl_full", r32, 1'b0);
    flush  = 1'b1;
    in_tag = 99;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", v32, 1'b0);
    check("fl_ready", r32, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("fl_no_ghost", v32, 1'b0);
    end
    // Flush with the buffer empty: the presented input must still be dropped
    flush    = 1'b1;
    in_valid = 1'b1;
    in_tag   = 98;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_drop_empty", v32, 1'b0);

    // Randomized traffic with occasional flushes and one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom % 4) != 0;
      in_instr  = gen_instr();
      in_tag    = tagc++;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      rst_n     = (i != 1500);
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
